// File: rtl/bus_mem_ctrl_if.sv
// Master-side data bus between the CPU core and bus_mem_ctrl.
// read/write are level-held by the master until the one-cycle ready pulse; the
// slave samples them only while idle, so the master may change them freely once ready is seen.
interface bus_mem_ctrl_if;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [1:0]  memType;
    logic [31:0] dataOut;
    logic [31:0] dataIn;
    logic        ready;
    logic        bus_err;

    modport master (output read, write, addr, memType, dataOut,
                    input  dataIn, ready, bus_err);
    modport slave  (input  read, write, addr, memType, dataOut,
                    output dataIn, ready, bus_err);
endinterface

// File: rtl/bus_mem_ctrl.sv
// Data-bus slave that turns byte/half/word requests into lane-enabled SRAM accesses.
// Optional misalignment rejection with bus_err: define BUSCTRL_ALIGN_CHECK_EN.
module bus_mem_ctrl #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 30
) (
    input  logic              clk,
    input  logic              res,
    bus_mem_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dbg_state_o
);
    localparam logic [1:0] MT_BYTE = 2'd0;
    localparam logic [1:0] MT_HALF = 2'd1;
    localparam logic [1:0] MT_WORD = 2'd2;
    localparam logic [1:0] MT_RSVD = 2'd3;
    localparam logic [3:0] LAT     = 4'(MEM_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                mem_re_q, mem_we_q, ready_q, bus_err_q;
    logic [31:0]         data_in_q, data_in_d;

    logic [1:0]          req_size, req_lane;
    logic                req_misaligned;
    logic [3:0]          req_be;
    logic [31:0]         req_wdata, rd_shift;

    // Decode the live request; only consumed while idle.
    always_comb begin
        req_size       = (bus.memType == MT_RSVD) ? MT_WORD : bus.memType;
        req_lane       = bus.addr[1:0];
        req_misaligned = 1'b0;
`ifdef BUSCTRL_ALIGN_CHECK_EN
        req_misaligned = ((req_size == MT_HALF) && bus.addr[0]) ||
                         ((req_size == MT_WORD) && (bus.addr[1:0] != 2'b00));
`else
        if (req_size == MT_HALF)      req_lane = {bus.addr[1], 1'b0};
        else if (req_size == MT_WORD) req_lane = 2'b00;
`endif
        case (req_size)
            MT_BYTE: begin
                req_be    = 4'b0001 << req_lane;
                req_wdata = {4{bus.dataOut[7:0]}};
            end
            MT_HALF: begin
                req_be    = 4'b0011 << req_lane;
                req_wdata = {2{bus.dataOut[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = bus.dataOut;
            end
        endcase
    end

    assign rd_shift = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        size_d      = size_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        data_in_d   = data_in_q;
        case (state_q)
            S_IDLE: begin
                if (bus.write || bus.read) begin
                    lane_d      = req_lane;
                    size_d      = req_size;
                    err_d       = req_misaligned;
                    mem_addr_d  = bus.addr[ADDR_W+1:2];
                    mem_be_d    = req_misaligned ? 4'b0000 : req_be;
                    mem_wdata_d = req_wdata;
                    if (req_misaligned) state_d = S_RESP;
                    else if (bus.write) state_d = S_WRITE;
                    else                state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = LAT;
            end
            S_WRITE: state_d = S_RESP;
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    case (size_q)
                        MT_BYTE: data_in_d = {24'h0, rd_shift[7:0]};
                        MT_HALF: data_in_d = {16'h0, rd_shift[15:0]};
                        default: data_in_d = mem_rdata;
                    endcase
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and ready are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ready_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            data_in_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= (state_d == S_READ);
            mem_we_q    <= (state_d == S_WRITE);
            ready_q     <= (state_d == S_RESP);
            bus_err_q   <= (state_d == S_RESP) && err_d;
            data_in_q   <= data_in_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign bus.dataIn  = data_in_q;
    assign bus.ready   = ready_q;
`ifdef BUSCTRL_ALIGN_CHECK_EN
    assign bus.bus_err = bus_err_q;
`else
    assign bus.bus_err = 1'b0;
`endif
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed bench: DUT0 at default latency with a writable SRAM model,
// DUT1 at MEM_LATENCY=4 with a preloaded read-only SRAM model.
module tb_bus_mem_ctrl;
    localparam logic [1:0] T_BYTE = 2'd0;
    localparam logic [1:0] T_HALF = 2'd1;
    localparam logic [1:0] T_WORD = 2'd2;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = 32'h0, req_data = 32'h0;
    logic [1:0]  req_type = 2'd0;

    bus_mem_ctrl_if b0 ();
    bus_mem_ctrl_if b1 ();
    assign b0.read = req_read & ~sel;
    assign b0.write = req_write & ~sel;
    assign b1.read = req_read & sel;
    assign b1.write = req_write & sel;
    assign b0.addr = req_addr;
    assign b1.addr = req_addr;
    assign b0.memType = req_type;
    assign b1.memType = req_type;
    assign b0.dataOut = req_data;
    assign b1.dataOut = req_data;

    logic [29:0] m0_addr, m1_addr;
    logic        m0_re, m0_we, m1_re, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [2:0]  dbg0, dbg1;

    bus_mem_ctrl u_dut0 (
        .clk(clk), .res(res), .bus(b0),
        .mem_addr(m0_addr), .mem_re(m0_re), .mem_we(m0_we), .mem_be(m0_be),
        .mem_wdata(m0_wdata), .mem_rdata(m0_rdata), .dbg_state_o(dbg0)
    );
    bus_mem_ctrl #(.MEM_LATENCY(4)) u_dut1 (
        .clk(clk), .res(res), .bus(b1),
        .mem_addr(m1_addr), .mem_re(m1_re), .mem_we(m1_we), .mem_be(m1_be),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .dbg_state_o(dbg1)
    );

    // SRAM models: DUT0 data valid one cycle after mem_re, DUT1 four cycles after.
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];
    logic [31:0] pipe0;
    logic [31:0] pipe1 [4];
    always @(posedge clk) begin
        if (m0_we)
            for (int k = 0; k < 4; k++)
                if (m0_be[k]) mem0[m0_addr[9:0]][8*k +: 8] <= m0_wdata[8*k +: 8];
        if (m0_re) pipe0 <= mem0[m0_addr[9:0]];
        pipe1[0] <= m1_re ? mem1[m1_addr[9:0]] : 32'h0;
        for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
    end
    assign m0_rdata = pipe0;
    assign m1_rdata = pipe1[3];
    initial begin
        for (int i = 0; i < 1024; i++) mem1[i] = 32'h0;
        mem1[10'h040] = 32'h12345678;
    end

    wire        o_ready = sel ? b1.ready : b0.ready;
    wire        o_err   = sel ? b1.bus_err : b0.bus_err;
    wire        o_re    = sel ? m1_re : m0_re;
    wire        o_we    = sel ? m1_we : m0_we;
    wire [3:0]  o_be    = sel ? m1_be : m0_be;
    wire [29:0] o_addr  = sel ? m1_addr : m0_addr;
    wire [31:0] o_wdata = sel ? m1_wdata : m0_wdata;
    wire [31:0] o_din   = sel ? b1.dataIn : b0.dataIn;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          rdy_cyc, re_n, we_n;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    logic [29:0] ma_s;
    logic        err_s;

    // Starts at a negedge in IDLE (cycle 0); returns one idle cycle after ready.
    task automatic access(input bit s, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [1:0] t, input logic [31:0] d);
        sel = s; req_addr = a; req_type = t; req_data = d;
        req_write = wr; req_read = rd;
        rdy_cyc = -1; re_n = 0; we_n = 0; be_s = 4'h0; wd_s = 32'h0; ma_s = 30'h0; err_s = 1'b0;
        for (int c = 1; c <= 40 && rdy_cyc < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (o_re) begin re_n++; be_s = o_be; ma_s = o_addr; end
            if (o_we) begin we_n++; be_s = o_be; ma_s = o_addr; wd_s = o_wdata; end
            if (o_ready) begin
                rdy_cyc = c; err_s = o_err;
                req_read = 1'b0; req_write = 1'b0;
            end
        end
        req_read = 1'b0; req_write = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    int rdy_pulses;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs0", {31'h0, |{b0.ready, b0.bus_err, m0_re, m0_we, m0_be, m0_addr, m0_wdata, b0.dataIn}}, 32'h0);
        chk("rst_state0", {29'h0, dbg0}, 32'h0);
        res = 1'b1;
        @(negedge clk);

        access(1'b0, 1'b1, 1'b0, 32'h100, T_WORD, 32'hDEADBEEF);
        chk("w1_rdy", rdy_cyc, 32'd2);
        chk("w1_we", we_n, 32'd1);
        chk("w1_be", {28'h0, be_s}, 32'hF);
        chk("w1_wdata", wd_s, 32'hDEADBEEF);
        chk("w1_addr", {2'b0, ma_s}, 32'h40);

        access(1'b0, 1'b0, 1'b1, 32'h100, T_WORD, 32'h0);
        chk("r1_rdy", rdy_cyc, 32'd3);
        chk("r1_re", re_n, 32'd1);
        chk("r1_data", o_din, 32'hDEADBEEF);

        access(1'b0, 1'b1, 1'b0, 32'h103, T_BYTE, 32'h1234565A);
        chk("wb_rdy", rdy_cyc, 32'd2);
        chk("wb_be", {28'h0, be_s}, 32'h8);
        chk("wb_wdata", wd_s, 32'h5A5A5A5A);

        access(1'b0, 1'b0, 1'b1, 32'h100, T_WORD, 32'h0);
        chk("r2_data", o_din, 32'h5AADBEEF);

        access(1'b0, 1'b0, 1'b1, 32'h101, T_BYTE, 32'h0);
        chk("rb_be", {28'h0, be_s}, 32'h2);
        chk("rb_data", o_din, 32'h000000BE);

        access(1'b0, 1'b1, 1'b1, 32'h200, T_WORD, 32'h7);
        chk("rw_we", we_n, 32'd1);
        chk("rw_re", re_n, 32'd0);
        chk("rw_rdy", rdy_cyc, 32'd2);
        chk("rw_din_kept", o_din, 32'h000000BE);

        access(1'b0, 1'b0, 1'b1, 32'h200, T_WORD, 32'h0);
        chk("r3_data", o_din, 32'h7);

        access(1'b0, 1'b1, 1'b0, 32'h202, T_HALF, 32'hFFFFABCD);
        chk("wh_be", {28'h0, be_s}, 32'hC);
        chk("wh_wdata", wd_s, 32'hABCDABCD);

        access(1'b0, 1'b0, 1'b1, 32'h200, T_WORD, 32'h0);
        chk("r4_data", o_din, 32'hABCD0007);
        access(1'b0, 1'b0, 1'b1, 32'h202, 2'd3, 32'h0);
        chk("rsvd_data", o_din, 32'hABCD0007);
        access(1'b0, 1'b0, 1'b1, 32'h202, T_HALF, 32'h0);
        chk("rh_data", o_din, 32'h0000ABCD);

        access(1'b0, 1'b0, 1'b1, 32'h102, T_WORD, 32'h0);
`ifdef BUSCTRL_ALIGN_CHECK_EN
        chk("mis_rdy", rdy_cyc, 32'd1);
        chk("mis_err", {31'h0, err_s}, 32'h1);
        chk("mis_re", re_n, 32'd0);
        chk("mis_data", o_din, 32'h0000ABCD);
`else
        chk("mis_rdy", rdy_cyc, 32'd3);
        chk("mis_err", {31'h0, err_s}, 32'h0);
        chk("mis_addr", {2'b0, ma_s}, 32'h40);
        chk("mis_data", o_din, 32'h5AADBEEF);
`endif

        access(1'b1, 1'b0, 1'b1, 32'h102, T_HALF, 32'h0);
        chk("l4_rdy", rdy_cyc, 32'd6);
        chk("l4_re", re_n, 32'd1);
        chk("l4_data", o_din, 32'h00001234);

        // Reset during WAIT of a DUT1 read.
        sel = 1'b1; req_addr = 32'h100; req_type = T_WORD; req_read = 1'b1;
        rdy_pulses = 0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (o_ready) rdy_pulses++;
        end
        chk("mid_state", {29'h0, dbg1}, 32'd3);
        res = 1'b0;
        #1;
        chk("mid_rst_outs", {31'h0, |{b1.ready, b1.bus_err, m1_re, m1_we, m1_be, m1_addr, m1_wdata, b1.dataIn}}, 32'h0);
        chk("mid_rst_state", {29'h0, dbg1}, 32'd0);
        req_read = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (o_ready) rdy_pulses++;
        end
        res = 1'b1;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (o_ready) rdy_pulses++;
        end
        chk("mid_no_ready", rdy_pulses, 32'd0);

        access(1'b1, 1'b0, 1'b1, 32'h100, T_WORD, 32'h0);
        chk("post_rdy", rdy_cyc, 32'd6);
        chk("post_data", o_din, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_mem_ctrl.md
# bus_mem_ctrl

Single-port memory controller that serves as the slave end of the CPU core's `DataBus`. It sits directly downstream of the multicycle core's instruction-fetch and load/store states. It accepts one level-held read or write request at a time and converts byte, halfword and word accesses into lane-enabled word accesses on a synchronous SRAM with fixed read latency. It returns a registered one-cycle `ready` pulse with aligned, zero-extended read data.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from the `mem_re` strobe cycle to valid `mem_rdata`. Legal range is 1..15.
- `ADDR_W`, default 30: word-address width driven on `mem_addr`.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `res` input 1: reset, asynchronous and active-low.
- `read` input 1: bus read request, held high until `ready`.
- `write` input 1: bus write request, held high until `ready`.
- `addr` input 32: byte address.
- `memType` input 2: access size, using `MemType` values `BYTE`, `HALF`, `WORD`. The reserved value is treated as `WORD`.
- `dataOut` input 32: write data from the master. Byte data is in `[7:0]`; halfword data is in `[15:0]`.
- `dataIn` output 32: read data to the master, right-aligned and zero-extended.
- `ready` output 1: one-cycle completion pulse.
- `bus_err` output 1: pulses with `ready` when the access was rejected.
- `mem_addr` output ADDR_W: word address, equal to `addr[ADDR_W+1:2]`.
- `mem_re` output 1: SRAM read strobe.
- `mem_we` output 1: SRAM write strobe.
- `mem_be` output 4: byte-lane enables; lane *k* is `[8k+7:8k]`.
- `mem_wdata` output 32: lane-replicated write data.
- `mem_rdata` input 32: SRAM read data.

## Operation
States:
- IDLE
  - Samples `write`, `read`, `addr`, `memType`, `dataOut` into holding registers.
  - Sampling happens only in IDLE; request lines seen in any other state are ignored.
  - If `write` is high → WRITE. Write has priority when `read` and `write` are both high.
  - Else if `read` is high → READ.
  - Else stay in IDLE.
- READ: `mem_re`=1 for exactly one cycle, with `mem_addr` and `mem_be` valid. Next state is WAIT, with the latency counter loaded to MEM_LATENCY.
- WRITE: `mem_we`=1 for exactly one cycle, with `mem_be` and `mem_wdata` valid. Next state is RESP.
- WAIT
  - The counter decrements every cycle.
  - In the cycle it reads 1, `mem_rdata` is captured into `dataIn`: the lane is selected by `addr[1:0]`, shifted to bit 0, and zero-extended to 32 bits.
  - Next state is RESP.
- RESP: `ready`=1 (plus `bus_err` if rejected) for one cycle. Next state is IDLE.

Lane rules:
- `BYTE`: `mem_be` = 1<<`addr[1:0]`; `mem_wdata` = `{4{dataOut[7:0]}}`.
- `HALF`: `mem_be` = `4'b0011` << `addr[1:0]`; `mem_wdata` = `{2{dataOut[15:0]}}`.
- `WORD`: `mem_be` = `4'b1111`; `mem_wdata` = `dataOut`.
- Little-endian.

Register and strobe behaviour:
- `dataIn` holds its last value between accesses and is unchanged by writes.
- Strobes are never asserted outside READ or WRITE. At most one access is outstanding.

## Timing
- Request visible in cycle 0 (IDLE).
- Write:
  - Strobe in cycle 1.
  - `ready` in cycle 2.
- Read:
  - Strobe in cycle 1.
  - `mem_rdata` valid in cycle 1+MEM_LATENCY.
  - `ready` and `dataIn` valid in cycle 2+MEM_LATENCY. With the default, that is cycle 3.
- Back-to-back: the cycle after RESP is IDLE and can sample a new request. A master that issues its next request in the same cycle `ready` is high is sampled one cycle later. Nothing is lost, because requests are level-held.
- All outputs are registered, so there is no combinational path from `read`/`write`/`ready` back to the master.
- Reset while `res`=0, asynchronously and regardless of state:
  - state=IDLE.
  - `ready`=0, `bus_err`=0, `mem_re`=0, `mem_we`=0.
  - `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `dataIn`=0.
- Reset asserted mid-access drops the access with no `ready`. A write strobe that is cut off by reset is not guaranteed to commit.

## Configuration
- `BUSCTRL_ALIGN_CHECK_EN` defined:
  - A `HALF` access with `addr[0]`=1, or a `WORD` access with `addr[1:0]`≠0, is rejected.
  - A rejected access skips READ/WRITE, asserts no strobe, and goes IDLE → RESP.
  - RESP asserts `ready`=1, `bus_err`=1; `dataIn` is unchanged.
- Not defined:
  - `bus_err` is tied to 0.
  - Misaligned accesses are force-aligned: `HALF` ignores `addr[0]`; `WORD` ignores `addr[1:0]`.

## Test plan
- Reset, then word write of `32'hDEADBEEF` to 0x100, then word read of 0x100 → write `ready` in cycle 2 with `mem_be`=`1111`; read `ready` in cycle 3 with `dataIn`=`32'hDEADBEEF`.
- Byte write of 0x5A to 0x103 over the previous word, then word read → `mem_be`=`1000`, `mem_wdata`=`32'h5A5A5A5A`; read returns `32'h5AADBEEF`. A byte read of 0x101 returns `32'h000000BE`.
- MEM_LATENCY=4, halfword read at 0x102 of word `32'h12345678` → `ready` in cycle 6 with `dataIn`=`32'h00001234`. Exactly one `mem_re` pulse.
- `read` and `write` high together at 0x200 with `dataOut`=7 → only `mem_we` pulses; a following read of 0x200 returns 7.
- With `BUSCTRL_ALIGN_CHECK_EN`, word read at 0x102 → no strobe, `ready`=`bus_err`=1 in cycle 1, `dataIn` unchanged. Without the macro, the same access reads word 0x100.
- Assert `res`=0 during WAIT of a read → all outputs are 0 immediately and no `ready` pulse appears. After release, a new read completes normally.
